// File: rtl/udp_cmd_pkg.sv
// Shared constants for the UDP command parser: FSM state encoding, default header bytes
// and the command codes understood by downstream control logic.
package udp_cmd_pkg;

   localparam logic [2:0] StHunt = 3'd0;
   localparam logic [2:0] StHdr  = 3'd1;
   localparam logic [2:0] StCmd  = 3'd2;
   localparam logic [2:0] StAddr = 3'd3;
   localparam logic [2:0] StDh   = 3'd4;
   localparam logic [2:0] StDl   = 3'd5;
   localparam logic [2:0] StChk  = 3'd6;

   localparam logic [7:0] DefaultHdr0 = 8'h55;
   localparam logic [7:0] DefaultHdr1 = 8'hAA;

   localparam logic [7:0] CmdStreamStart = 8'h01;
   localparam logic [7:0] CmdStreamStop  = 8'h02;
   localparam logic [7:0] CmdRegWrite    = 8'h10;

endpackage

// File: rtl/udp_cmd_chksum.sv
// 8-bit additive checksum accumulator for udp_cmd_parser; only instantiated when
// UDP_CMD_CHKSUM_EN is defined.
module udp_cmd_chksum (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clr_i,
   input  logic       add_i,
   input  logic [7:0] data_i,
   output logic [7:0] sum_o
);

   logic [7:0] sum_d, sum_q;

   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = 8'h00;
      end else if (add_i) begin
         sum_d = sum_q + data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/udp_cmd_parser.sv
// Parses UDP payload bytes into HDR0 HDR1 CMD ADDR DH DL [CHK] command frames.
// Define UDP_CMD_CHKSUM_EN to add the trailing checksum byte and err_chk.
module udp_cmd_parser
   import udp_cmd_pkg::*;
#(
   parameter logic [7:0]  HDR0  = DefaultHdr0,
   parameter logic [7:0]  HDR1  = DefaultHdr1,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             udp_rx_en,
   input  logic [7:0]       udp_idata,
   input  logic             udp_rx_done,
   output logic             cmd_valid,
   output logic [7:0]       cmd_code,
   output logic [7:0]       cmd_addr,
   output logic [15:0]      cmd_data,
   output logic             err_chk,
   output logic             err_trunc,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   logic [2:0]       state_d, state_q;
   logic [7:0]       code_d, code_q, addr_d, addr_q, dh_d, dh_q;
   logic [7:0]       cmd_code_d, cmd_code_q, cmd_addr_d, cmd_addr_q;
   logic [15:0]      cmd_data_d, cmd_data_q;
   logic             valid_d, valid_q, trunc_d, trunc_q;
   logic             chk_fail, frame_end, in_frame;
   logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

   assign in_frame = (state_q != StHunt) && (state_q != StHdr);

`ifdef UDP_CMD_CHKSUM_EN
   logic [7:0] dl_d, dl_q, sum;
   logic       chk_q;

   udp_cmd_chksum u_chksum (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (udp_rx_en && (state_q == StHdr) && (udp_idata == HDR1)),
      .add_i   (udp_rx_en && in_frame && (state_q != StChk)),
      .data_i  (udp_idata),
      .sum_o   (sum)
   );
`endif

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      addr_d     = addr_q;
      dh_d       = dh_q;
      cmd_code_d = cmd_code_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
      valid_d    = 1'b0;
      trunc_d    = 1'b0;
      chk_fail   = 1'b0;
      frame_end  = 1'b0;
`ifdef UDP_CMD_CHKSUM_EN
      dl_d       = dl_q;
`endif
      if (udp_rx_en) begin
         case (state_q)
            StHunt: if (udp_idata == HDR0) state_d = StHdr;
            StHdr: begin
               if (udp_idata == HDR1)      state_d = StCmd;
               else if (udp_idata != HDR0) state_d = StHunt;
            end
            StCmd:  begin code_d = udp_idata; state_d = StAddr; end
            StAddr: begin addr_d = udp_idata; state_d = StDh;   end
            StDh:   begin dh_d   = udp_idata; state_d = StDl;   end
`ifdef UDP_CMD_CHKSUM_EN
            StDl:   begin dl_d   = udp_idata; state_d = StChk;  end
            StChk: begin
               frame_end = 1'b1;
               state_d   = StHunt;
               if (udp_idata == sum) begin
                  valid_d    = 1'b1;
                  cmd_code_d = code_q;
                  cmd_addr_d = addr_q;
                  cmd_data_d = {dh_q, dl_q};
               end else begin
                  chk_fail = 1'b1;
               end
            end
`else
            StDl: begin
               frame_end  = 1'b1;
               state_d    = StHunt;
               valid_d    = 1'b1;
               cmd_code_d = code_q;
               cmd_addr_d = addr_q;
               cmd_data_d = {dh_q, udp_idata};
            end
`endif
            default: state_d = StHunt;
         endcase
      end
      // End of packet wins over any partial progress, but never over a completed frame
      if (udp_rx_done && !frame_end) begin
         state_d = StHunt;
         trunc_d = in_frame;
      end
      err_cnt_d = err_cnt_q;
      if ((chk_fail || trunc_d) && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StHunt;
         code_q     <= 8'h00;
         addr_q     <= 8'h00;
         dh_q       <= 8'h00;
         cmd_code_q <= 8'h00;
         cmd_addr_q <= 8'h00;
         cmd_data_q <= 16'h0000;
         valid_q    <= 1'b0;
         trunc_q    <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         addr_q     <= addr_d;
         dh_q       <= dh_d;
         cmd_code_q <= cmd_code_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_data_q <= cmd_data_d;
         valid_q    <= valid_d;
         trunc_q    <= trunc_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

`ifdef UDP_CMD_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         dl_q  <= 8'h00;
         chk_q <= 1'b0;
      end else begin
         dl_q  <= dl_d;
         chk_q <= chk_fail;
      end
   end

   assign err_chk = chk_q;
`else
   assign err_chk = 1'b0;
`endif

   assign cmd_valid = valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_data  = cmd_data_q;
   assign err_trunc = trunc_q;
   assign err_cnt   = err_cnt_q;
   assign busy      = (state_q != 3'd0);

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Directed self-checking bench for udp_cmd_parser; adapts frame length to UDP_CMD_CHKSUM_EN.
module tb_udp_cmd_parser;

`ifdef UDP_CMD_CHKSUM_EN
   localparam int unsigned FL = 7;
`else
   localparam int unsigned FL = 6;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        udp_rx_en;
   logic [7:0]  udp_idata;
   logic        udp_rx_done;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        err_chk;
   logic        err_trunc;
   logic [7:0]  err_cnt;
   logic        busy;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_cnt = 8'h00;

   udp_cmd_parser dut (
      .clk         (clk),
      .reset       (reset),
      .udp_rx_en   (udp_rx_en),
      .udp_idata   (udp_idata),
      .udp_rx_done (udp_rx_done),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .err_chk     (err_chk),
      .err_trunc   (err_trunc),
      .err_cnt     (err_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Presents one byte for exactly one edge; returns 1 time unit after that edge.
   task automatic put(input logic [7:0] b, input logic done);
      udp_rx_en   = 1'b1;
      udp_idata   = b;
      udp_rx_done = done;
      @(posedge clk); #1;
      udp_rx_en   = 1'b0;
      udp_rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic done_pulse();
      udp_rx_done = 1'b1;
      @(posedge clk); #1;
      udp_rx_done = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] ck, input logic last_done);
      put(8'h55, 1'b0); put(8'hAA, 1'b0); put(c, 1'b0); put(a, 1'b0); put(dh, 1'b0);
`ifdef UDP_CMD_CHKSUM_EN
      put(dl, 1'b0); put(ck, last_done);
`else
      if (ck == 8'h00) udp_idata = 8'h00;
      put(dl, last_done);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; udp_rx_en = 1'b0; udp_idata = 8'h00; udp_rx_done = 1'b0;
      idle(3);
      reset = 1'b0;
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cmd_valid); end
      checks++; if (cmd_code !== 8'h00) begin errors++; $display("FAIL rst_code: got %h want 00", cmd_code); end
      checks++; if (cmd_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", cmd_addr); end
      checks++; if (cmd_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", cmd_data); end
      checks++; if (err_chk !== 1'b0) begin errors++; $display("FAIL rst_chk: got %b want 0", err_chk); end
      checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL rst_trunc: got %b want 0", err_trunc); end
      checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h want 00", err_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_good_frame();
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h57, 1'b0);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", cmd_valid); end
      checks++; if (cmd_code !== 8'h01) begin errors++; $display("FAIL good_code: got %h want 01", cmd_code); end
      checks++; if (cmd_addr !== 8'h10) begin errors++; $display("FAIL good_addr: got %h want 10", cmd_addr); end
      checks++; if (cmd_data !== 16'h1234) begin errors++; $display("FAIL good_data: got %h want 1234", cmd_data); end
      checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL good_cnt: got %h want 00", err_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b want 0", busy); end
      idle(1);
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL good_pulse: got %b want 0", cmd_valid); end
      checks++; if (cmd_code !== 8'h01) begin errors++; $display("FAIL good_hold: got %h want 01", cmd_code); end
   endtask

`ifdef UDP_CMD_CHKSUM_EN
   task automatic test_bad_chksum();
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h58, 1'b0);
      exp_cnt++;
      checks++; if (err_chk !== 1'b1) begin errors++; $display("FAIL bad_chk: got %b want 1", err_chk); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL bad_cnt: got %h want %h", err_cnt, exp_cnt); end
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b want 0", cmd_valid); end
      checks++; if (cmd_data !== 16'h1234) begin errors++; $display("FAIL bad_data: got %h want 1234", cmd_data); end
      idle(1);
      checks++; if (err_chk !== 1'b0) begin errors++; $display("FAIL bad_pulse: got %b want 0", err_chk); end
   endtask
`endif

   task automatic test_resync();
      put(8'h55, 1'b0);
      send_frame(8'h02, 8'h00, 8'h00, 8'h01, 8'h03, 1'b0);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b want 1", cmd_valid); end
      checks++; if (cmd_code !== 8'h02) begin errors++; $display("FAIL resync_code: got %h want 02", cmd_code); end
      checks++; if (cmd_data !== 16'h0001) begin errors++; $display("FAIL resync_data: got %h want 0001", cmd_data); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL resync_cnt: got %h want %h", err_cnt, exp_cnt); end
      idle(1);
   endtask

   task automatic test_trunc();
      put(8'h55, 1'b0); put(8'hAA, 1'b0); put(8'h10, 1'b0); put(8'h20, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL trunc_busy_pre: got %b want 1", busy); end
      done_pulse();
      exp_cnt++;
      checks++; if (err_trunc !== 1'b1) begin errors++; $display("FAIL trunc_pulse: got %b want 1", err_trunc); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL trunc_cnt: got %h want %h", err_cnt, exp_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_busy: got %b want 0", busy); end
      checks++; if (cmd_code !== 8'h02) begin errors++; $display("FAIL trunc_code: got %h want 02", cmd_code); end
      idle(1);
      checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL trunc_end: got %b want 0", err_trunc); end
      // Done while hunting or after a header byte is not an error
      put(8'h55, 1'b0);
      done_pulse();
      checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL trunc_hdr: got %b want 0", err_trunc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_hdr_busy: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int unsigned t1;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h57, 1'b1);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL lastdone_valid: got %b want 1", cmd_valid); end
      checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL lastdone_trunc: got %b want 0", err_trunc); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL lastdone_cnt: got %h want %h", err_cnt, exp_cnt); end
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h57, 1'b0);
      t1 = cyc;
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", cmd_valid); end
      send_frame(8'h10, 8'h05, 8'hAB, 8'hCD, 8'h8D, 1'b1);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b want 1", cmd_valid); end
      checks++; if (cyc - t1 !== FL) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - t1, FL); end
      checks++; if (cmd_code !== 8'h10) begin errors++; $display("FAIL b2b_code: got %h want 10", cmd_code); end
      checks++; if (cmd_data !== 16'hABCD) begin errors++; $display("FAIL b2b_data: got %h want abcd", cmd_data); end
      idle(1);
   endtask

   task automatic test_gaps();
      logic [7:0] b [7];
      b = '{8'h55, 8'hAA, 8'h01, 8'h22, 8'h00, 8'h07, 8'h2A};
      for (int i = 0; i < int'(FL); i++) begin
         put(b[i], 1'b0);
         if (i != int'(FL) - 1) idle(3);
         if (i == 3) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", busy); end
         end
      end
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", cmd_valid); end
      checks++; if (cmd_addr !== 8'h22) begin errors++; $display("FAIL gap_addr: got %h want 22", cmd_addr); end
      checks++; if (cmd_data !== 16'h0007) begin errors++; $display("FAIL gap_data: got %h want 0007", cmd_data); end
      idle(1);
   endtask

   task automatic test_reset_mid();
      put(8'h55, 1'b0); put(8'hAA, 1'b0); put(8'h01, 1'b0); put(8'h10, 1'b0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      exp_cnt = 8'h00;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
      checks++; if (cmd_code !== 8'h00) begin errors++; $display("FAIL mrst_code: got %h want 00", cmd_code); end
      checks++; if (cmd_data !== 16'h0000) begin errors++; $display("FAIL mrst_data: got %h want 0000", cmd_data); end
      checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL mrst_cnt: got %h want 00", err_cnt); end
      checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL mrst_trunc: got %b want 0", err_trunc); end
      send_frame(8'h02, 8'h33, 8'h44, 8'h55, 8'hCE, 1'b0);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL mrst_valid: got %b want 1", cmd_valid); end
      checks++; if (cmd_code !== 8'h02) begin errors++; $display("FAIL mrst_fcode: got %h want 02", cmd_code); end
      checks++; if (cmd_data !== 16'h4455) begin errors++; $display("FAIL mrst_fdata: got %h want 4455", cmd_data); end
      idle(1);
   endtask

   task automatic bad_frame();
`ifdef UDP_CMD_CHKSUM_EN
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h00, 1'b0);
`else
      put(8'h55, 1'b0); put(8'hAA, 1'b0); put(8'h01, 1'b0);
      done_pulse();
`endif
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 254; i++) bad_frame();
      idle(1);
      checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL sat_fe: got %h want fe", err_cnt); end
      for (int i = 0; i < 46; i++) bad_frame();
      idle(1);
      checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_ff: got %h want ff", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
`ifdef UDP_CMD_CHKSUM_EN
      test_bad_chksum();
`endif
      test_resync();
      test_trunc();
      test_back_to_back();
      test_gaps();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
